// File: rtl/serial_compare_controller.sv
// serial_compare_controller: unsigned magnitude comparator that reuses one
// 2-bit slice comparator. It scans the operands MSB-first, two bits per clock,
// and reports equal / greater / less through a start/done handshake.
// Optional feature macro: SERIAL_CMP_EARLY_EXIT_EN. When it is defined, the
// first unequal slice ends the scan. Without it, the scan always covers every
// slice, so the latency is the same for all operands.
module serial_compare_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             A_greater,
  output logic             A_less
);

  localparam int S  = WIDTH / 2;
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [IW-1:0]    idx;
  logic [1:0]       sliceA;
  logic [1:0]       sliceB;
  logic             sliceEq;
  logic             sliceGt;
  logic             sliceLt;
  logic             lastSlice;
  logic             accept;
  logic             loadResult;
  logic             resEq;
  logic             resGt;
  logic             resLt;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
  logic             decided;
  logic             decGt;
`endif

  // The operand registers shift left each compare step, so the slice being
  // examined is always the top two bits; idx only tracks how many remain.
  always_comb begin
    sliceA    = aReg[WIDTH-1 -: 2];
    sliceB    = bReg[WIDTH-1 -: 2];
    sliceEq   = (sliceA == sliceB);
    sliceGt   = (sliceA > sliceB);
    sliceLt   = (sliceA < sliceB);
    lastSlice = (idx == '0);
  end

  // Next-state logic, plus the result that gets written on entry to DONE.
  always_comb begin
    stateNext  = state;
    accept     = 1'b0;
    loadResult = 1'b0;
    resEq      = 1'b0;
    resGt      = 1'b0;
    resLt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = COMPARE;
        end
      end
      COMPARE: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (!sliceEq) begin
          loadResult = 1'b1;
          resGt      = sliceGt;
          resLt      = sliceLt;
          stateNext  = DONE;
        end else if (lastSlice) begin
          loadResult = 1'b1;
          resEq      = 1'b1;
          stateNext  = DONE;
        end
`else
        if (lastSlice) begin
          loadResult = 1'b1;
          resGt      = decided ? decGt  : sliceGt;
          resLt      = decided ? !decGt : sliceLt;
          resEq      = !decided && sliceEq;
          stateNext  = DONE;
        end
`endif
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register. busy and done are registered from the next state, so no
  // input reaches an output without passing through a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext != IDLE);
      done  <= (stateNext == DONE);
    end
  end

  // Operand capture on the accepting edge, then one slice shift per compare cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg <= '0;
      bReg <= '0;
      idx  <= '0;
    end else if (accept) begin
      aReg <= A;
      bReg <= B;
      idx  <= IW'(S - 1);
    end else if (state == COMPARE) begin
      aReg <= aReg << 2;
      bReg <= bReg << 2;
      idx  <= idx - 1'b1;
    end
  end

`ifndef SERIAL_CMP_EARLY_EXIT_EN
  // The first unequal slice decides the outcome. Later slices cannot override it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decided <= 1'b0;
      decGt   <= 1'b0;
    end else if (accept) begin
      decided <= 1'b0;
      decGt   <= 1'b0;
    end else if (state == COMPARE && !decided && !sliceEq) begin
      decided <= 1'b1;
      decGt   <= sliceGt;
    end
  end
`endif

  // Result flags change only on the edge that enters DONE and then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      equal     <= 1'b0;
      A_greater <= 1'b0;
      A_less    <= 1'b0;
    end else if (loadResult) begin
      equal     <= resEq;
      A_greater <= resGt;
      A_less    <= resLt;
    end
  end

endmodule

// File: tb/tb_serial_compare_controller.sv
// tb_serial_compare_controller: directed, table-driven bench for
// serial_compare_controller with WIDTH=8. It follows the same
// SERIAL_CMP_EARLY_EXIT_EN macro as the design when computing latencies.
module tb_serial_compare_controller;

  localparam int WIDTH = 8;
  localparam int S     = WIDTH / 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             equal;
  logic             A_greater;
  logic             A_less;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             expEq;
    logic             expGt;
    logic             expLt;
    int               misSlice;
  } vector_t;

  vector_t vecs[8];

  serial_compare_controller #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .equal     (equal),
    .A_greater (A_greater),
    .A_less    (A_less)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected start-to-done latency in edges after E0. misSlice is the first
  // unequal slice counted from the MSB (1), or 0 when all slices match.
  function automatic int expLatency(input int misSlice);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    return (misSlice == 0) ? S : misSlice;
`else
    return S;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Pulse start for one edge (E0) with the given operands, then scramble the
  // operand inputs and count edges until done is seen. Returns -1 on timeout.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               output int lat);
    lat = -1;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A     = ~a;
    B     = a;
    checkOutput("busy_after_accept", int'(busy), 1);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int doneCount;
    int firstDone;
    int secondDone;
    bit sawDone;

    vecs[0] = '{8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 4};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0};
    vecs[4] = '{8'hFF, 8'hFE, 1'b0, 1'b1, 1'b0, 4};
    vecs[5] = '{8'h3C, 8'hC3, 1'b0, 1'b0, 1'b1, 1};
    vecs[6] = '{8'h4F, 8'h47, 1'b0, 1'b1, 1'b0, 3};
    vecs[7] = '{8'h5A, 8'h59, 1'b0, 1'b1, 1'b0, 4};

    start = 1'b0;
    A     = '0;
    B     = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;

    // Reset state with no start.
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_equal", int'(equal), 0);
    checkOutput("rst_gt", int'(A_greater), 0);
    checkOutput("rst_lt", int'(A_less), 0);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat);
      $display("[TB] vector %0d A=%h B=%h latency=%0d", i, vecs[i].a, vecs[i].b, lat);
      checkOutput("latency", lat, expLatency(vecs[i].misSlice));
      checkOutput("equal", int'(equal), int'(vecs[i].expEq));
      checkOutput("A_greater", int'(A_greater), int'(vecs[i].expGt));
      checkOutput("A_less", int'(A_less), int'(vecs[i].expLt));
      checkOutput("busy_in_done", int'(busy), 1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("done_one_cycle", int'(done), 0);
      checkOutput("busy_after_done", int'(busy), 0);
      checkOutput("result_hold", int'(A_greater), int'(vecs[i].expGt));
    end

    // Start held high continuously: one accept per IDLE visit, so done
    // pulses are spaced S+2 cycles apart.
    @(negedge clk);
    A          = 8'h01;
    B          = 8'h00;
    start      = 1'b1;
    doneCount  = 0;
    firstDone  = -1;
    secondDone = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        doneCount++;
        if (doneCount == 1) firstDone = c;
        else secondDone = c;
        checkOutput("held_start_gt", int'(A_greater), 1);
        if (doneCount == 2) break;
      end
    end
    start = 1'b0;
    checkOutput("held_start_first_done", firstDone, S + 1);
    checkOutput("held_start_spacing", secondDone - firstDone, S + 2);
    @(posedge clk);
    @(negedge clk);
    checkOutput("held_start_idle", int'(busy), 0);

    // Reset during a compare: outputs clear at once, no done pulse follows.
    @(negedge clk);
    A     = 8'hFF;
    B     = 8'h00;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_equal", int'(equal), 0);
    checkOutput("abort_gt", int'(A_greater), 0);
    checkOutput("abort_lt", int'(A_less), 0);
    sawDone = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", int'(sawDone), 0);

    applyStimulus(8'hFF, 8'h00, lat);
    checkOutput("post_reset_latency", lat, expLatency(1));
    checkOutput("post_reset_gt", int'(A_greater), 1);
    checkOutput("post_reset_eq", int'(equal), 0);
    checkOutput("post_reset_lt", int'(A_less), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
